// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core load/store port vs. host burst port with starvation guard.
// Optional stall/burst statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 8,
   parameter int MAX_BURST    = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_gnt,
   output logic          core_stall,
   output logic [DW-1:0] core_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [4:0]    host_len,
   input  logic [DW-1:0] host_wdata,
   output logic          host_wready,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   output logic          host_busy,
   output logic          host_done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [15:0]   stat_stall,
   output logic [15:0]   stat_bursts
);

   typedef enum logic {IDLE, HOST} state_t;

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   state_t        state_reg;
   logic [AW-1:0] base_reg;
   logic [4:0]    len_reg;
   logic [4:0]    beat_reg;
   logic          we_reg;
   logic [SW-1:0] starve_reg;
   logic          host_done_reg;
   logic          host_rvalid_reg;
   logic [DW-1:0] host_rdata_reg;

   logic          host_sel;
   logic          last_beat;
   logic [4:0]    len_clip;

   always_comb begin
      len_clip = host_len;
      if (host_len == 5'd0)
         len_clip = 5'd1;
      else if (host_len > 5'(MAX_BURST))
         len_clip = 5'(MAX_BURST);
   end

   assign host_sel  = RST_N && (state_reg == IDLE) && host_req &&
                      (!core_req || (starve_reg == SW'(STARVE_LIMIT)));
   assign last_beat = (beat_reg == (len_reg - 5'd1));

   // Combinational outputs are gated by RST_N so everything reads 0 while reset is held.
   always_comb begin
      core_gnt    = 1'b0;
      core_rdata  = '0;
      host_wready = 1'b0;
      host_busy   = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      if (RST_N) begin
         if (state_reg == HOST) begin
            host_busy   = 1'b1;
            mem_addr    = base_reg + AW'(beat_reg);
            mem_we      = we_reg;
            host_wready = we_reg;
            if (we_reg)
               mem_wdata = host_wdata;
         end else if (host_sel) begin
            host_busy = 1'b1;
         end else if (core_req) begin
            core_gnt   = 1'b1;
            mem_addr   = core_addr;
            mem_we     = core_we;
            mem_wdata  = core_wdata;
            core_rdata = mem_rdata;
         end
      end
   end

   assign core_stall  = RST_N && core_req && !core_gnt;
   assign host_done   = host_done_reg;
   assign host_rvalid = host_rvalid_reg;
   assign host_rdata  = host_rdata_reg;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg       <= IDLE;
         base_reg        <= '0;
         len_reg         <= '0;
         beat_reg        <= '0;
         we_reg          <= 1'b0;
         starve_reg      <= '0;
         host_done_reg   <= 1'b0;
         host_rvalid_reg <= 1'b0;
         host_rdata_reg  <= '0;
      end else begin
         host_done_reg   <= 1'b0;
         host_rvalid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (host_sel) begin
                  base_reg   <= host_addr;
                  len_reg    <= len_clip;
                  we_reg     <= host_we;
                  beat_reg   <= '0;
                  starve_reg <= '0;
                  state_reg  <= HOST;
               end else if (host_req && core_req) begin
                  starve_reg <= starve_reg + SW'(1);
               end else if (!host_req) begin
                  starve_reg <= '0;
               end
            end
            HOST: begin
               // Read data is captured at the beat and presented one cycle later.
               if (!we_reg) begin
                  host_rvalid_reg <= 1'b1;
                  host_rdata_reg  <= mem_rdata;
               end
               if (last_beat) begin
                  state_reg     <= IDLE;
                  beat_reg      <= '0;
                  host_done_reg <= 1'b1;
               end else begin
                  beat_reg <= beat_reg + 5'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stat_stall_reg;
   logic [15:0] stat_bursts_reg;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stat_stall_reg  <= '0;
         stat_bursts_reg <= '0;
      end else begin
         if (core_stall && (stat_stall_reg != 16'hFFFF))
            stat_stall_reg <= stat_stall_reg + 16'd1;
         if (host_done_reg && (stat_bursts_reg != 16'hFFFF))
            stat_bursts_reg <= stat_bursts_reg + 16'd1;
      end
   end

   assign stat_stall  = stat_stall_reg;
   assign stat_bursts = stat_bursts_reg;
`else
   assign stat_stall  = 16'd0;
   assign stat_bursts = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256x8 memory model (combinational read, synchronous write).
module tb_dmem_arbiter;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       core_req, core_we;
   logic [7:0] core_addr, core_wdata;
   logic       core_gnt, core_stall;
   logic [7:0] core_rdata;
   logic       host_req, host_we;
   logic [7:0] host_addr;
   logic [4:0] host_len;
   logic [7:0] host_wdata;
   logic       host_wready, host_rvalid, host_busy, host_done;
   logic [7:0] host_rdata;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we;
   logic [15:0] stat_stall, stat_bursts;

   logic [7:0] mem [256];
   logic       mem_clr;
   logic [7:0] wdat [16];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   dmem_arbiter dut (
      .CLK(CLK), .RST_N(RST_N),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_stall(core_stall), .core_rdata(core_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
      .host_wdata(host_wdata), .host_wready(host_wready), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata), .host_busy(host_busy), .host_done(host_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stat_stall(stat_stall), .stat_bursts(stat_bursts)
   );

   assign mem_rdata = mem[mem_addr];

   always @(posedge CLK) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   // Write burst using wdat[]; checks acceptance, every beat and the done cycle.
   task automatic host_write(input logic [7:0] base, input logic [4:0] len, input int nbeats);
      logic [7:0] a;
      next_cycle();
      host_req = 1'b1; host_we = 1'b1; host_addr = base; host_len = len;
      @(negedge CLK);
      check_eq("wr_accept_busy", host_busy, 1);
      check_eq("wr_accept_memwe", mem_we, 0);
      check_eq("wr_accept_wready", host_wready, 0);
      for (int k = 0; k < nbeats; k++) begin
         next_cycle();
         host_req = 1'b0;
         host_wdata = wdat[k];
         a = base + 8'(k);
         @(negedge CLK);
         check_eq($sformatf("wr_beat%0d_addr", k), mem_addr, a);
         check_eq($sformatf("wr_beat%0d_wready", k), host_wready, 1);
         check_eq($sformatf("wr_beat%0d_nodone", k), host_done, 0);
      end
      next_cycle();
      @(negedge CLK);
      check_eq("wr_done", host_done, 1);
      check_eq("wr_done_busy", host_busy, 0);
      check_eq("wr_done_wready", host_wready, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic done_seen;
      RST_N = 1'b0; mem_clr = 1'b1;
      core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
      host_req = 0; host_we = 0; host_addr = 0; host_len = 0; host_wdata = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_eq("rst_gnt", core_gnt, 0);
      check_eq("rst_busy", host_busy, 0);
      check_eq("rst_done", host_done, 0);
      check_eq("rst_rvalid", host_rvalid, 0);
      check_eq("rst_memwe", mem_we, 0);
      check_eq("rst_stats", {stat_stall, stat_bursts}, 0);
      next_cycle();
      RST_N = 1'b1; mem_clr = 1'b0;

      // Basic host write
      wdat[0] = 8'h90; wdat[1] = 8'h6D;
      host_write(8'h40, 5'd2, 2);
      check_eq("mem40", mem[8'h40], 8'h90);
      check_eq("mem41", mem[8'h41], 8'h6D);

      // Preload then read back
      wdat[0] = 8'h78; wdat[1] = 8'h03;
      host_write(8'h00, 5'd2, 2);
      next_cycle();
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h00; host_len = 5'd2;
      @(negedge CLK);
      check_eq("rd_accept_busy", host_busy, 1);
      next_cycle();
      host_req = 1'b0;
      @(negedge CLK);
      check_eq("rd_beat0_rvalid", host_rvalid, 0);
      check_eq("rd_beat0_memwe", mem_we, 0);
      next_cycle();
      @(negedge CLK);
      check_eq("rd_beat1_rvalid", host_rvalid, 1);
      check_eq("rd_beat1_rdata", host_rdata, 8'h78);
      check_eq("rd_beat1_nodone", host_done, 0);
      next_cycle();
      @(negedge CLK);
      check_eq("rd_last_rvalid", host_rvalid, 1);
      check_eq("rd_last_rdata", host_rdata, 8'h03);
      check_eq("rd_done", host_done, 1);
      check_eq("rd_done_busy", host_busy, 0);

      // Wrap and length clipping
      for (int k = 0; k < 16; k++) wdat[k] = 8'hC0 + 8'(k);
      host_write(8'hFF, 5'd3, 3);
      check_eq("wrap_memFF", mem[8'hFF], 8'hC0);
      check_eq("wrap_mem00", mem[8'h00], 8'hC1);
      check_eq("wrap_mem01", mem[8'h01], 8'hC2);
      host_write(8'h80, 5'd0, 1);
      check_eq("len0_mem80", mem[8'h80], 8'hC0);
      check_eq("len0_mem81", mem[8'h81], 8'h00);
      host_write(8'h90, 5'd31, 16);
      check_eq("len31_mem9F", mem[8'h9F], 8'hCF);
      check_eq("len31_memA0", mem[8'hA0], 8'h00);

      // Starvation: continuous core loads of 0x40, host read of 0x40..0x41
      next_cycle();
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h40;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40; host_len = 5'd2;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         check_eq($sformatf("starve_gnt%0d", i), core_gnt, 1);
         check_eq($sformatf("starve_rdata%0d", i), core_rdata, 8'h90);
         next_cycle();
      end
      @(negedge CLK);
      check_eq("starve_accept_gnt", core_gnt, 0);
      check_eq("starve_accept_stall", core_stall, 1);
      check_eq("starve_accept_busy", host_busy, 1);
      next_cycle();
      host_req = 1'b0;
      @(negedge CLK);
      check_eq("starve_beat0_stall", core_stall, 1);
      next_cycle();
      @(negedge CLK);
      check_eq("starve_beat1_stall", core_stall, 1);
      check_eq("starve_beat1_rdata", host_rdata, 8'h90);
      next_cycle();
      @(negedge CLK);
      check_eq("starve_resume_gnt", core_gnt, 1);
      check_eq("starve_resume_done", host_done, 1);
      check_eq("starve_resume_rdata", host_rdata, 8'h6D);

      // Core store then load
      next_cycle();
      core_we = 1'b1; core_addr = 8'h10; core_wdata = 8'hA5;
      @(negedge CLK);
      check_eq("st_gnt", core_gnt, 1);
      check_eq("st_stall", core_stall, 0);
      check_eq("st_memwe", mem_we, 1);
      next_cycle();
      core_we = 1'b0;
      @(negedge CLK);
      check_eq("ld_gnt", core_gnt, 1);
      check_eq("ld_rdata", core_rdata, 8'hA5);
      next_cycle();
      core_req = 1'b0;

      // Reset in beat 2 of an 8-beat write at 0x20
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_len = 5'd8;
      next_cycle();
      host_req = 1'b0; host_wdata = 8'hD0;
      next_cycle();
      host_wdata = 8'hD1;
      next_cycle();
      host_wdata = 8'hD2;
      RST_N = 1'b0;
      #1;
      check_eq("rstmid_memwe", mem_we, 0);
      check_eq("rstmid_wready", host_wready, 0);
      check_eq("rstmid_busy", host_busy, 0);
      check_eq("rstmid_addr", mem_addr, 0);
      done_seen = 1'b0;
      next_cycle();
      RST_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (host_done || host_busy) done_seen = 1'b1;
         next_cycle();
      end
      check_eq("rstmid_no_done", done_seen, 0);
      check_eq("rstmid_mem20", mem[8'h20], 8'hD0);
      check_eq("rstmid_mem21", mem[8'h21], 8'hD1);
      check_eq("rstmid_mem22", mem[8'h22], 8'h00);
      core_req = 1'b1; core_addr = 8'h20;
      @(negedge CLK);
      check_eq("rstmid_idle_gnt", core_gnt, 1);
      check_eq("rstmid_idle_rdata", core_rdata, 8'hD0);
      next_cycle();
      core_req = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
